// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter
//   Shares one SPI RAM controller between NUM_PORTS requesters (for example
//   loader/debug, CPU instruction fetch and CPU data access). Requests are
//   arbitrated round-robin. The winner's command is latched, and a
//   single-cycle start_read or start_write is issued to the controller. The
//   arbiter then waits for the controller to finish and returns read data
//   with a one-cycle done pulse to the winning port.
//
// Ports
//   clk, rst_n       clock; synchronous active-low reset (shared with controller)
//   req, we          per-port request level and write enable (1 = write)
//   addr, wdata      packed per-port address / write data, port i at [i*W +: W]
//   gnt              one-cycle pulse: that port's command was accepted
//   done             one-cycle pulse: that port's access has completed
//   rdata            read data, valid while done is high, held between accesses
//   busy             arbiter is not idle
//   mem_*            controller command interface (addr/data/start/busy/rdata)

module spi_ram_arbiter #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_PORTS-1:0]           req,
    input  logic [NUM_PORTS-1:0]           we,
    input  logic [NUM_PORTS*ADDR_BITS-1:0] addr,
    input  logic [NUM_PORTS*DATA_BITS-1:0] wdata,
    output logic [NUM_PORTS-1:0]           gnt,
    output logic [NUM_PORTS-1:0]           done,
    output logic [DATA_BITS-1:0]           rdata,
    output logic                           busy,
    output logic [ADDR_BITS-1:0]           mem_addr,
    output logic [DATA_BITS-1:0]           mem_wdata,
    output logic                           mem_start_read,
    output logic                           mem_start_write,
    input  logic [DATA_BITS-1:0]           mem_rdata,
    input  logic                           mem_busy
);

    localparam int PTR_W = $clog2(NUM_PORTS);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [PTR_W-1:0]     win_q, win_d;
    logic                 we_q, we_d;
    logic                 first_q, first_d;
    logic [NUM_PORTS-1:0] gnt_q, gnt_d;
    logic [NUM_PORTS-1:0] done_q, done_d;
    logic [DATA_BITS-1:0] rdata_q, rdata_d;
    logic                 busy_q, busy_d;
    logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_BITS-1:0] mem_wdata_q, mem_wdata_d;
    logic                 start_rd_q, start_rd_d;
    logic                 start_wr_q, start_wr_d;
    logic [PTR_W-1:0]     winner;

    logic [ADDR_BITS-1:0] addr_arr  [NUM_PORTS];
    logic [DATA_BITS-1:0] wdata_arr [NUM_PORTS];

    // Unpack the flat per-port buses so the winner can be selected by index.
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign addr_arr[g]  = addr[g*ADDR_BITS +: ADDR_BITS];
        assign wdata_arr[g] = wdata[g*DATA_BITS +: DATA_BITS];
    end

    // First set request searching upward from the pointer, wrapping modulo
    // NUM_PORTS. The sum never exceeds 2*NUM_PORTS-2, so a single
    // conditional subtract is enough for the wrap.
    function automatic logic [PTR_W-1:0] pick_winner(
        input logic [NUM_PORTS-1:0] r,
        input logic [PTR_W-1:0]     ptr
    );
        logic [PTR_W-1:0] win;
        logic             found;
        logic [PTR_W:0]   idx;
        win   = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = {1'b0, ptr} + (PTR_W+1)'(i);
            if (idx >= (PTR_W+1)'(NUM_PORTS)) begin
                idx = idx - (PTR_W+1)'(NUM_PORTS);
            end
            if (!found && r[idx[PTR_W-1:0]]) begin
                found = 1'b1;
                win   = idx[PTR_W-1:0];
            end
        end
        return win;
    endfunction

    function automatic logic [NUM_PORTS-1:0] onehot(input logic [PTR_W-1:0] i);
        logic [NUM_PORTS-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    assign winner = pick_winner(req, ptr_q);

    // Next-state and registered-output logic. Pulses default low, and
    // holding registers default to their current value.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        we_d        = we_q;
        first_d     = 1'b0;
        gnt_d       = '0;
        done_d      = '0;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        start_rd_d  = 1'b0;
        start_wr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d     = ISSUE;
                    win_d       = winner;
                    we_d        = we[winner];
                    mem_addr_d  = addr_arr[winner];
                    mem_wdata_d = wdata_arr[winner];
                    gnt_d       = onehot(winner);
                    start_rd_d  = !we[winner];
                    start_wr_d  = we[winner];
                    ptr_d       = (winner == PTR_W'(NUM_PORTS-1)) ? '0 : winner + 1'b1;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                first_d = 1'b1;
            end
            WAIT: begin
                // The controller raises busy only one cycle after the start,
                // so mem_busy is meaningless in the first WAIT cycle.
                if (!first_q && !mem_busy) begin
                    state_d = IDLE;
                    done_d  = onehot(win_q);
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            win_q       <= '0;
            we_q        <= 1'b0;
            first_q     <= 1'b0;
            gnt_q       <= '0;
            done_q      <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            start_rd_q  <= 1'b0;
            start_wr_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            we_q        <= we_d;
            first_q     <= first_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            start_rd_q  <= start_rd_d;
            start_wr_q  <= start_wr_d;
        end
    end

    assign gnt             = gnt_q;
    assign done            = done_q;
    assign rdata           = rdata_q;
    assign busy            = busy_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;
    assign mem_start_read  = start_rd_q;
    assign mem_start_write = start_wr_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb_spi_ram_arbiter
//   Self-checking bench for spi_ram_arbiter. A behavioural SPI RAM controller
//   with a programmable busy time serves the arbiter. A transaction-level
//   reference model runs alongside and predicts every output in every cycle
//   from the requests the arbiter sampled. Directed table vectors, hand-written
//   contention, fairness and reset sequences, and a randomized phase drive it.

module tb_spi_ram_arbiter;

    localparam int NP = 3;
    localparam int AB = 16;
    localparam int DB = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NP-1:0]    req;
    logic [NP-1:0]    we;
    logic [NP*AB-1:0] addr;
    logic [NP*DB-1:0] wdata;
    logic [NP-1:0]    gnt;
    logic [NP-1:0]    done;
    logic [DB-1:0]    rdata;
    logic             busy;
    logic [AB-1:0]    mem_addr;
    logic [DB-1:0]    mem_wdata;
    logic             mem_start_read;
    logic             mem_start_write;
    logic [DB-1:0]    mem_rdata;
    logic             mem_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ctl_busy_len = 2;

    always #5 clk = ~clk;

    spi_ram_arbiter #(
        .NUM_PORTS (NP),
        .ADDR_BITS (AB),
        .DATA_BITS (DB)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req             (req),
        .we              (we),
        .addr            (addr),
        .wdata           (wdata),
        .gnt             (gnt),
        .done            (done),
        .rdata           (rdata),
        .busy            (busy),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_start_read  (mem_start_read),
        .mem_start_write (mem_start_write),
        .mem_rdata       (mem_rdata),
        .mem_busy        (mem_busy)
    );

    function automatic logic [15:0] init_word(input int i);
        return (i == 16) ? 16'hBEEF : 16'(32'hA000 + i);
    endfunction

    // Controller model: 256-word memory, busy for ctl_busy_len cycles
    // starting the cycle after a start pulse.
    logic [15:0] ctl_mem [256];
    int          ctl_left;

    always @(posedge clk) begin
        if (!rst_n) begin
            mem_busy  <= 1'b0;
            ctl_left  <= 0;
            mem_rdata <= '0;
            for (int i = 0; i < 256; i++) ctl_mem[i] <= init_word(i);
        end else if (mem_start_read || mem_start_write) begin
            if (mem_start_write) ctl_mem[mem_addr[7:0]] <= mem_wdata;
            else                 mem_rdata <= ctl_mem[mem_addr[7:0]];
            mem_busy <= (ctl_busy_len > 0);
            ctl_left <= ctl_busy_len;
        end else if (ctl_left > 1) begin
            ctl_left <= ctl_left - 1;
        end else begin
            mem_busy <= 1'b0;
            ctl_left <= 0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model state: at most one access outstanding.
    logic [15:0]   ref_mem [256];
    bit            outstanding = 1'b0;
    int            o_port, o_gnt, o_done;
    logic          o_we;
    logic [15:0]   o_addr, o_wdata, o_exp;
    int            ref_ptr = 0;
    logic [15:0]   ref_rdata = '0, ref_maddr = '0, ref_mwdata = '0;
    logic          s_rst;
    logic [NP-1:0] s_req, s_we;
    logic [NP*AB-1:0] s_addr;
    logic [NP*DB-1:0] s_wdata;
    int            s_len;

    function automatic logic [NP-1:0] port_bit(input int p);
        logic [NP-1:0] v;
        v    = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    // Cycle-by-cycle reference model: samples what the arbiter saw at the
    // edge, then compares every output 1 time unit later.
    initial begin
        logic [NP-1:0] e_gnt, e_done;
        forever begin
            @(posedge clk);
            cyc++;
            s_rst = rst_n; s_req = req; s_we = we; s_addr = addr; s_wdata = wdata;
            s_len = ctl_busy_len;
            if (!s_rst) begin
                outstanding = 1'b0;
                ref_ptr = 0; ref_rdata = '0; ref_maddr = '0; ref_mwdata = '0;
                for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
            end else begin
                if (outstanding && cyc == o_gnt + 1)
                    o_done = o_gnt + 2 + ((s_len > 1) ? s_len : 1);
                if (!outstanding && |s_req) begin
                    int w;
                    w = -1;
                    for (int k = 0; k < NP; k++) begin
                        int p;
                        p = (ref_ptr + k) % NP;
                        if (w < 0 && s_req[p]) w = p;
                    end
                    outstanding = 1'b1;
                    o_port  = w;
                    o_we    = s_we[w];
                    o_addr  = s_addr[w*AB +: AB];
                    o_wdata = s_wdata[w*DB +: DB];
                    o_gnt   = cyc;
                    o_done  = 32'h7fffffff;
                    ref_ptr = (w + 1) % NP;
                    ref_maddr  = o_addr;
                    ref_mwdata = o_wdata;
                    if (o_we) ref_mem[o_addr[7:0]] = o_wdata;
                    else      o_exp = ref_mem[o_addr[7:0]];
                end
            end
            #1;
            e_gnt  = (outstanding && cyc == o_gnt)  ? port_bit(o_port) : '0;
            e_done = (outstanding && cyc == o_done) ? port_bit(o_port) : '0;
            if (outstanding && cyc == o_done && !o_we) ref_rdata = o_exp;
            checkOutput("model_gnt", 32'(gnt), 32'(e_gnt));
            checkOutput("model_done", 32'(done), 32'(e_done));
            checkOutput("model_busy", 32'(busy), 32'(outstanding && cyc != o_done));
            checkOutput("model_start_read", 32'(mem_start_read), 32'(outstanding && cyc == o_gnt && !o_we));
            checkOutput("model_start_write", 32'(mem_start_write), 32'(outstanding && cyc == o_gnt && o_we));
            checkOutput("model_mem_addr", 32'(mem_addr), 32'(ref_maddr));
            checkOutput("model_mem_wdata", 32'(mem_wdata), 32'(ref_mwdata));
            checkOutput("model_rdata", 32'(rdata), 32'(ref_rdata));
            if (outstanding && cyc == o_done) outstanding = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic drive_port(input int p, input logic r, input logic w,
                              input logic [15:0] a, input logic [15:0] d);
        req[p] = r;
        we[p]  = w;
        addr[p*AB +: AB]  = a;
        wdata[p*DB +: DB] = d;
    endtask

    task automatic wait_gnt(input int p, input int limit, output int lat, output bit ok);
        lat = 0; ok = 1'b0;
        while (lat < limit && !ok) begin
            @(posedge clk); #1;
            lat++;
            if (gnt[p]) ok = 1'b1;
        end
    endtask

    task automatic wait_done(input int p, input int limit, output int lat, output bit ok);
        lat = 0; ok = 1'b0;
        while (lat < limit && !ok) begin
            @(posedge clk); #1;
            lat++;
            if (done[p]) ok = 1'b1;
        end
    endtask

    task automatic wait_any_gnt(input int limit, output int port, output bit ok);
        int n;
        n = 0; ok = 1'b0; port = -1;
        while (n < limit && !ok) begin
            @(posedge clk); #1;
            n++;
            for (int p = 0; p < NP; p++) if (gnt[p]) begin port = p; ok = 1'b1; end
        end
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (busy !== 1'b0 && n < limit);
        checkOutput(name, 32'(busy), 32'd0);
    endtask

    typedef struct {
        int          port;
        logic        wr;
        logic [15:0] a;
        logic [15:0] d;
        int          busy_len;
        logic [15:0] exp_rdata;
        int          exp_done_lat;
    } vec_t;

    task automatic applyStimulus(input vec_t v);
        int lat;
        bit ok;
        @(negedge clk);
        ctl_busy_len = v.busy_len;
        drive_port(v.port, 1'b1, v.wr, v.a, v.d);
        wait_gnt(v.port, 10, lat, ok);
        checkOutput("gnt_seen", 32'(ok), 32'd1);
        checkOutput("gnt_latency", 32'(lat), 32'd1);
        @(negedge clk);
        drive_port(v.port, 1'b0, 1'b0, 16'h0, 16'h0);
        wait_done(v.port, 60, lat, ok);
        checkOutput("done_seen", 32'(ok), 32'd1);
        checkOutput("done_latency", 32'(lat), 32'(v.exp_done_lat));
        checkOutput("rdata_at_done", 32'(rdata), 32'(v.exp_rdata));
        checkOutput("busy_at_done", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    vec_t vecs [6];

    initial begin
        int  port, lat, dcount;
        bit  ok;
        bit  pending [NP];

        // Done latency after gnt is 2 + max(1, controller busy cycles).
        vecs[0] = '{1, 1'b0, 16'h0010, 16'h0000, 20, 16'hBEEF, 22};
        vecs[1] = '{2, 1'b1, 16'h0100, 16'h1234, 20, 16'hBEEF, 22};
        vecs[2] = '{0, 1'b0, 16'h0100, 16'h0000,  5, 16'h1234,  7};
        vecs[3] = '{1, 1'b1, 16'h0005, 16'h5A5A,  1, 16'h1234,  3};
        vecs[4] = '{2, 1'b0, 16'h0005, 16'h0000,  0, 16'h5A5A,  3};
        vecs[5] = '{0, 1'b0, 16'h0010, 16'h0000,  3, 16'hBEEF,  5};

        req = '0; we = '0; addr = '0; wdata = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_rdata", 32'(rdata), 32'd0);

        $display("[TB] directed table");
        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

        $display("[TB] contention from reset");
        @(negedge clk);
        rst_n = 1'b0;
        ctl_busy_len = 2;
        for (int p = 0; p < NP; p++) drive_port(p, 1'b1, 1'b0, 16'(p), 16'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_any_gnt(40, port, ok);
            checkOutput("contention_order", 32'(port), 32'(k % NP));
        end
        @(negedge clk);
        req = '0;
        wait_idle("contention_idle", 40);

        $display("[TB] fairness");
        @(negedge clk);
        ctl_busy_len = 4;
        drive_port(1, 1'b1, 1'b0, 16'h0020, 16'h0);
        wait_gnt(1, 10, lat, ok);
        checkOutput("fair_first_gnt", 32'(ok), 32'd1);
        repeat (2) @(negedge clk);
        drive_port(2, 1'b1, 1'b1, 16'h0030, 16'h7777);
        wait_any_gnt(40, port, ok);
        checkOutput("fair_next_port", 32'(port), 32'd2);
        @(negedge clk);
        drive_port(2, 1'b0, 1'b0, 16'h0, 16'h0);
        wait_any_gnt(40, port, ok);
        checkOutput("fair_after_port", 32'(port), 32'd1);
        @(negedge clk);
        drive_port(1, 1'b0, 1'b0, 16'h0, 16'h0);
        wait_idle("fair_idle", 40);

        $display("[TB] randomized traffic");
        for (int p = 0; p < NP; p++) pending[p] = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            ctl_busy_len = int'($urandom_range(0, 6));
            for (int p = 0; p < NP; p++) begin
                if (pending[p] && gnt[p]) begin
                    pending[p] = 1'b0;
                    req[p] = 1'b0;
                end
                if (!pending[p] && n < 2900 && $urandom_range(0, 7) == 0) begin
                    pending[p] = 1'b1;
                    drive_port(p, 1'b1, 1'($urandom_range(0, 1)),
                               16'($urandom_range(0, 7)), 16'($urandom));
                end
            end
        end
        for (int p = 0; p < NP; p++) checkOutput("random_all_served", 32'(pending[p]), 32'd0);
        @(negedge clk);
        req = '0;
        wait_idle("random_idle", 60);

        $display("[TB] reset during WAIT");
        @(negedge clk);
        ctl_busy_len = 20;
        drive_port(1, 1'b1, 1'b0, 16'h0010, 16'h0);
        wait_gnt(1, 10, lat, ok);
        checkOutput("rstwait_gnt", 32'(ok), 32'd1);
        @(negedge clk);
        drive_port(1, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("rst_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_start", 32'({mem_start_read, mem_start_write}), 32'd0);
        checkOutput("rst_rdata", 32'(rdata), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            if (|done) dcount++;
        end
        checkOutput("no_done_after_reset", 32'(dcount), 32'd0);
        applyStimulus('{0, 1'b0, 16'h0010, 16'h0000, 2, 16'hBEEF, 4});

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
